// File: rtl/aib_axi_lite_pkg.sv
// Shared definitions for the AIB AXI4-Lite bridge.
// Contents:
//   frame_type_e  - 3-bit frame type codes carried in bits [78:76]
//   field offsets - bit positions and widths of every frame field
//   frame_t       - packed view of one 80-bit phy word
//   IdleFrame     - all-zero word driven whenever nothing is sent
//   make_frame    - builds a valid request word from its fields
package aib_axi_lite_pkg;

  localparam int unsigned FrameW = 80;

  typedef enum logic [2:0] {
    FtWr   = 3'b001,
    FtRd   = 3'b010,
    FtRrsp = 3'b011,
    FtBrsp = 3'b100
  } frame_type_e;

  // Field map: [79] valid, [78:76] type, [75:72] wstrb, [71:40] addr,
  // [39:8] data, [7:2] reserved zero, [1:0] resp.
  localparam int unsigned ValidBit = 79;
  localparam int unsigned TypeLsb  = 76;
  localparam int unsigned TypeW    = 3;
  localparam int unsigned StrbLsb  = 72;
  localparam int unsigned StrbW    = 4;
  localparam int unsigned AddrLsb  = 40;
  localparam int unsigned AddrW    = 32;
  localparam int unsigned DataLsb  = 8;
  localparam int unsigned DataW    = 32;
  localparam int unsigned PadLsb   = 2;
  localparam int unsigned PadW     = 6;
  localparam int unsigned RespLsb  = 0;
  localparam int unsigned RespW    = 2;

  typedef struct packed {
    logic              valid;
    frame_type_e       ftype;
    logic [StrbW-1:0]  wstrb;
    logic [AddrW-1:0]  addr;
    logic [DataW-1:0]  data;
    logic [PadW-1:0]   pad;
    logic [RespW-1:0]  resp;
  } frame_t;

  localparam frame_t IdleFrame = '0;

  function automatic frame_t make_frame(input frame_type_e      ftype,
                                        input logic [StrbW-1:0] wstrb,
                                        input logic [AddrW-1:0] addr,
                                        input logic [DataW-1:0] data);
    frame_t f;
    f.valid = 1'b1;
    f.ftype = ftype;
    f.wstrb = wstrb;
    f.addr  = addr;
    f.data  = data;
    f.pad   = '0;
    f.resp  = '0;
    return f;
  endfunction

endpackage

// File: rtl/aib_axi_lite_rsp_fifo.sv
// Synchronous response FIFO used on the rx side of the leader bridge.
// Ports:
//   clk_i    - clock
//   rst_ni   - synchronous active-low reset (empties the FIFO)
//   push_i   - write wdata_i; accepted when not full, or when full with a same-cycle pop
//   wdata_i  - entry to store
//   pop_i    - drop the head entry; ignored when empty
//   rdata_o  - head entry (valid while !empty_o)
//   full_o   - Depth entries stored
//   empty_o  - no entries stored
// A push into an empty FIFO shows on rdata_o/empty_o the following cycle.
module aib_axi_lite_rsp_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             do_push, do_pop;

  // Pointers wrap at Depth, which need not be a power of two.
  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_comb begin
    full_o  = (cnt_q == CntW'(Depth));
    empty_o = (cnt_q == '0);
    do_pop  = pop_i & ~empty_o;
    do_push = push_i & (~full_o | do_pop);
    rdata_o = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only observed behind cnt_q.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/aib_axi_lite_leader_packer.sv
// Leader-side AXI4-Lite bridge core.
// Acts as AXI-Lite slave to the local user, packs WR (AW+W) and RD (AR) requests into 80-bit
// phy words on tx_phy0, and unpacks RRSP/BRSP words from rx_phy0 onto the R and B channels.
// Ports:
//   clk_wr, rst_wr_n       - bridge clock, synchronous active-low reset
//   tx_online, rx_online   - link may transmit / receive (rx_phy0 ignored while rx_online=0)
//   tx_phy0                - registered request word, all-zero when idle
//   rx_phy0                - response word from the link
//   s_aw*, s_w*, s_b*      - AXI-Lite write address, write data, write response
//   s_ar*, s_r*            - AXI-Lite read address, read data
//   proto_err              - sticky flag for any dropped rx frame; cleared only by reset
// Frame fields are fixed at 32-bit address/data; PHY_WIDTH is expected to be 80.
module aib_axi_lite_leader_packer
  import aib_axi_lite_pkg::*;
#(
  parameter int unsigned ADDRWIDTH = 32,
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned MAX_OUT   = 4,
  parameter int unsigned PHY_WIDTH = 80
) (
  input  logic                   clk_wr,
  input  logic                   rst_wr_n,
  input  logic                   tx_online,
  input  logic                   rx_online,
  output logic [PHY_WIDTH-1:0]   tx_phy0,
  input  logic [PHY_WIDTH-1:0]   rx_phy0,
  input  logic [ADDRWIDTH-1:0]   s_awaddr,
  input  logic                   s_awvalid,
  output logic                   s_awready,
  input  logic [DATAWIDTH-1:0]   s_wdata,
  input  logic [DATAWIDTH/8-1:0] s_wstrb,
  input  logic                   s_wvalid,
  output logic                   s_wready,
  output logic [1:0]             s_bresp,
  output logic                   s_bvalid,
  input  logic                   s_bready,
  input  logic [ADDRWIDTH-1:0]   s_araddr,
  input  logic                   s_arvalid,
  output logic                   s_arready,
  output logic [DATAWIDTH-1:0]   s_rdata,
  output logic [1:0]             s_rresp,
  output logic                   s_rvalid,
  input  logic                   s_rready,
  output logic                   proto_err
);

  localparam int unsigned CntW   = $clog2(MAX_OUT + 1);
  localparam int unsigned RFifoW = DataW + RespW;

  typedef enum logic [0:0] {
    StOffline = 1'b0,
    StOnline  = 1'b1
  } link_state_e;

  link_state_e     link_q;
  frame_t          tx_q, tx_d;
  logic            rr_q;  // 0: WR wins a tie, 1: RD wins a tie
  logic [CntW-1:0] rd_out_q, wr_out_q;
  logic            proto_err_q;

  logic              online;
  logic              gnt_wr, gnt_rd, wr_elig, rd_elig;
  logic              r_pop, b_pop;
  logic              r_push, b_push, rx_bad, rx_take;
  logic [TypeW-1:0]  rx_type;
  logic              r_full, r_empty, b_full, b_empty;
  logic [RFifoW-1:0] r_head;
  logic [RespW-1:0]  b_head;
  logic              unused_rx;

  // ---------------------------------------------------------------------------
  // Response FIFOs
  // ---------------------------------------------------------------------------
  aib_axi_lite_rsp_fifo #(
    .Depth (MAX_OUT),
    .Width (RFifoW)
  ) u_rd_rsp_fifo (
    .clk_i   (clk_wr),
    .rst_ni  (rst_wr_n),
    .push_i  (r_push),
    .wdata_i ({rx_phy0[DataLsb +: DataW], rx_phy0[RespLsb +: RespW]}),
    .pop_i   (r_pop),
    .rdata_o (r_head),
    .full_o  (r_full),
    .empty_o (r_empty)
  );

  aib_axi_lite_rsp_fifo #(
    .Depth (MAX_OUT),
    .Width (RespW)
  ) u_wr_rsp_fifo (
    .clk_i   (clk_wr),
    .rst_ni  (rst_wr_n),
    .push_i  (b_push),
    .wdata_i (rx_phy0[RespLsb +: RespW]),
    .pop_i   (b_pop),
    .rdata_o (b_head),
    .full_o  (b_full),
    .empty_o (b_empty)
  );

  // Request-only fields carry nothing useful on the rx side.
  assign unused_rx = ^{rx_phy0[StrbLsb +: StrbW], rx_phy0[AddrLsb +: AddrW],
                       rx_phy0[PadLsb +: PadW]};

  // ---------------------------------------------------------------------------
  // User-facing response channels
  // ---------------------------------------------------------------------------
  always_comb begin
    s_rvalid = ~r_empty;
    s_rdata  = DATAWIDTH'(r_head[RFifoW-1:RespW]);
    s_rresp  = r_head[RespW-1:0];
    s_bvalid = ~b_empty;
    s_bresp  = b_head;
    r_pop    = s_rvalid & s_rready;
    b_pop    = s_bvalid & s_bready;
  end

  // ---------------------------------------------------------------------------
  // Arbiter: a same-cycle pop frees a slot, so a full counter can still grant.
  // ---------------------------------------------------------------------------
  always_comb begin
    online  = (link_q == StOnline);
    wr_elig = online & s_awvalid & s_wvalid & ((wr_out_q < CntW'(MAX_OUT)) | b_pop);
    rd_elig = online & s_arvalid & ((rd_out_q < CntW'(MAX_OUT)) | r_pop);
    gnt_wr  = wr_elig & (~rd_elig | ~rr_q);
    gnt_rd  = rd_elig & ~gnt_wr;

    s_awready = gnt_wr;
    s_wready  = gnt_wr;
    s_arready = gnt_rd;

    if (gnt_wr) begin
      tx_d = make_frame(FtWr, StrbW'(s_wstrb), AddrW'(s_awaddr), DataW'(s_wdata));
    end else if (gnt_rd) begin
      tx_d = make_frame(FtRd, '0, AddrW'(s_araddr), '0);
    end else begin
      tx_d = IdleFrame;
    end
  end

  // ---------------------------------------------------------------------------
  // Rx decode: only RRSP/BRSP are meaningful towards the leader.
  // ---------------------------------------------------------------------------
  always_comb begin
    rx_take = rx_online & rx_phy0[ValidBit];
    rx_type = rx_phy0[TypeLsb +: TypeW];
    r_push  = 1'b0;
    b_push  = 1'b0;
    rx_bad  = 1'b0;
    if (rx_take) begin
      case (rx_type)
        FtRrsp: begin
          if ((rd_out_q == '0) || r_full) rx_bad = 1'b1;
          else                            r_push = 1'b1;
        end
        FtBrsp: begin
          if ((wr_out_q == '0) || b_full) rx_bad = 1'b1;
          else                            b_push = 1'b1;
        end
        default: rx_bad = 1'b1;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Link FSM, tx register, round-robin pointer, counters, error flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_wr) begin
    if (!rst_wr_n) begin
      link_q      <= StOffline;
      tx_q        <= IdleFrame;
      rr_q        <= 1'b0;
      rd_out_q    <= '0;
      wr_out_q    <= '0;
      proto_err_q <= 1'b0;
    end else begin
      case (link_q)
        StOffline: if (tx_online)  link_q <= StOnline;
        StOnline:  if (!tx_online) link_q <= StOffline;
        default:                   link_q <= StOffline;
      endcase

      tx_q <= tx_d;
      if (gnt_wr | gnt_rd) rr_q <= ~rr_q;

      case ({gnt_rd, r_pop})
        2'b10:   rd_out_q <= rd_out_q + CntW'(1);
        2'b01:   rd_out_q <= rd_out_q - CntW'(1);
        default: rd_out_q <= rd_out_q;
      endcase

      case ({gnt_wr, b_pop})
        2'b10:   wr_out_q <= wr_out_q + CntW'(1);
        2'b01:   wr_out_q <= wr_out_q - CntW'(1);
        default: wr_out_q <= wr_out_q;
      endcase

      if (rx_bad) proto_err_q <= 1'b1;
    end
  end

  assign tx_phy0   = PHY_WIDTH'(tx_q);
  assign proto_err = proto_err_q;

endmodule
